// File: rtl/timer_sched.sv
// Multi-channel interval timer: a shared prescaler drives per-channel down-counters
// that toggle an LED on expiry. Expiry events are serialised round-robin onto a
// single valid/ready event port.
module timer_sched #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned PRESCALE = 25_000_000,
    parameter int unsigned CNTW     = 16,
    parameter int unsigned CHW      = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [CHW-1:0]  cmd_ch,
    input  logic [CNTW-1:0] cmd_data,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CHW-1:0]  evt_ch,
    output logic [NCH-1:0]  led,
    output logic [NCH-1:0]  busy,
    output logic [NCH-1:0]  ovf
);

    // A single-cycle prescaler still needs a 1-bit register.
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        OpLoad  = 2'd0,
        OpStart = 2'd1,
        OpStop  = 2'd2,
        OpClear = 2'd3
    } op_e;

    logic [PW-1:0]   presc_q, presc_d;
    logic            tick;
    logic            ready_q;

    logic [CNTW-1:0] period_q [NCH];
    logic [CNTW-1:0] period_d [NCH];
    logic [CNTW-1:0] count_q  [NCH];
    logic [CNTW-1:0] count_d  [NCH];
    logic [NCH-1:0]  running_q, running_d;
    logic [NCH-1:0]  led_q, led_d;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [NCH-1:0]  ovf_q, ovf_d;

    logic            evt_valid_q, evt_valid_d;
    logic [CHW-1:0]  evt_ch_q, evt_ch_d;
    logic [CHW-1:0]  rr_ptr_q, rr_ptr_d;

    logic            cmd_fire;
    logic [NCH-1:0]  hit;
    logic            out_free;
    logic            found;
    logic            grant;
    logic [CHW-1:0]  gnt_ch;
    logic [CHW-1:0]  scan_ch;
    int unsigned     scan_idx;

    assign cmd_fire  = cmd_valid && ready_q;
    assign cmd_ready = ready_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign led       = led_q;
    assign busy      = running_q;
    assign ovf       = ovf_q;

    // Prescaler wrap and tick strobe.
    always_comb begin
        tick    = (presc_q == PrescMax);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Round-robin scan of pending bits starting at rr_ptr.
    always_comb begin
        out_free = !evt_valid_q || evt_ready;
        found    = 1'b0;
        gnt_ch   = '0;
        scan_idx = 0;
        scan_ch  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            scan_idx = (32'(rr_ptr_q) + i) % NCH;
            scan_ch  = CHW'(scan_idx);
            if (!found && pending_q[scan_ch]) begin
                found  = 1'b1;
                gnt_ch = scan_ch;
            end
        end
        grant = out_free && found;

        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (out_free) begin
            evt_valid_d = found;
            if (found) begin
                evt_ch_d = gnt_ch;
                rr_ptr_d = CHW'((32'(gnt_ch) + 1) % NCH);
            end
        end
    end

    // Per-channel commands and counting; a command on a channel masks its tick.
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            hit[c]       = cmd_fire && (32'(cmd_ch) == c);
            period_d[c]  = period_q[c];
            count_d[c]   = count_q[c];
            running_d[c] = running_q[c];
            led_d[c]     = led_q[c];
            ovf_d[c]     = ovf_q[c];
            pending_d[c] = pending_q[c];
            if (grant && (32'(gnt_ch) == c)) begin
                pending_d[c] = 1'b0;
            end
            if (hit[c]) begin
                case (cmd_op)
                    OpLoad: begin
                        period_d[c] = cmd_data;
                        count_d[c]  = cmd_data;
                    end
                    OpStart: begin
                        if (period_q[c] != '0) begin
                            running_d[c] = 1'b1;
                            count_d[c]   = period_q[c];
                        end
                    end
                    OpStop: begin
                        running_d[c] = 1'b0;
                    end
                    OpClear: begin
                        running_d[c] = 1'b0;
                        count_d[c]   = period_q[c];
                        led_d[c]     = 1'b0;
                        pending_d[c] = 1'b0;
                        ovf_d[c]     = 1'b0;
                    end
                    default: ;
                endcase
            end else if (running_q[c] && tick) begin
                if (count_q[c] > CNTW'(1)) begin
                    count_d[c] = count_q[c] - CNTW'(1);
                end else if (count_q[c] == CNTW'(1)) begin
                    // New expiry overrides a same-cycle grant clear.
                    count_d[c]   = period_q[c];
                    led_d[c]     = ~led_q[c];
                    pending_d[c] = 1'b1;
                    if (pending_q[c]) begin
                        ovf_d[c] = 1'b1;
                    end
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            ready_q     <= 1'b0;
            running_q   <= '0;
            led_q       <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            rr_ptr_q    <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                period_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            presc_q     <= presc_d;
            ready_q     <= 1'b1;
            running_q   <= running_d;
            led_q       <= led_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            period_q    <= period_d;
            count_q     <= count_d;
        end
    end

endmodule
